// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Registers the decoded control word and operands into EX. On a load-use
// dependency it freezes PC and IF/ID for one cycle and writes a bubble.
// It squashes the decode instruction on flush and freezes on hold.
// Optional build macro HAZARD_STATS_EN adds saturating bubble/flush counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        id_ctrl,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic [9:0]        ex_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic [9:0]        ctrl_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] rs_data_p0;
  logic [DATA_W-1:0] rt_data_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] pc4_p0;
  logic [REG_W-1:0]  rs_p0;
  logic [REG_W-1:0]  rt_p0;
  logic [REG_W-1:0]  rd_p0;

  logic uses_rt;
  logic rt_hit;
  logic load_en;
  logic kill;

  // Stores (MemWrite) and R-type (ALUSrc=0) instructions read rt as a source.
  assign uses_rt = ~id_ctrl[8] | id_ctrl[7];
  assign rt_hit  = (rt_p0 == id_rs) | (uses_rt & (rt_p0 == id_rt));

  // A load in EX feeding the decode instruction; $0 never forwards a real value.
  assign stall = id_valid & vld_p0 & ctrl_p0[3] & (rt_p0 != '0) & rt_hit
               & ~flush & ~hold;

  // Reset forces the upstream enables open so fetch restarts cleanly.
  assign pc_write   = rst | ~(stall | hold);
  assign ifid_write = pc_write;

  // Flush overrides hold; otherwise hold freezes the whole register.
  assign load_en = flush | ~hold;
  assign kill    = flush | stall | ~id_valid;

  // ---- ID -> EX boundary: control word and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (load_en) begin
      ctrl_p0 <= kill ? 10'd0 : id_ctrl;
      vld_p0  <= ~kill;
    end
  end

  // ---- ID -> EX boundary: operands and specifiers (loaded even on bubble)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_p0 <= '0;
      rt_data_p0 <= '0;
      imm_p0     <= '0;
      pc4_p0     <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      rd_p0      <= '0;
    end else if (load_en) begin
      rs_data_p0 <= id_rs_data;
      rt_data_p0 <= id_rt_data;
      imm_p0     <= id_imm;
      pc4_p0     <= id_pc4;
      rs_p0      <= id_rs;
      rt_p0      <= id_rt;
      rd_p0      <= id_rd;
    end
  end

  assign ex_ctrl    = ctrl_p0;
  assign ex_valid   = vld_p0;
  assign ex_rs_data = rs_data_p0;
  assign ex_rt_data = rt_data_p0;
  assign ex_imm     = imm_p0;
  assign ex_pc4     = pc4_p0;
  assign ex_rs      = rs_p0;
  assign ex_rt      = rt_p0;
  assign ex_rd      = rd_p0;

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count stall bubbles and applied flushes, holding at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall) bubble_cnt <= sat_inc(bubble_cnt);
      if (flush) flush_cnt  <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the ID/EX register.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        id_ctrl;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic              flush, hold;
  logic [9:0]        ex_ctrl;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic              stall, pc_write, ifid_write;
`ifdef HAZARD_STATS_EN
  logic [15:0]       bubble_cnt, flush_cnt;
`endif

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .hold(hold), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef HAZARD_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // What the EX stage should currently hold, one instruction-slot record.
  typedef struct {
    logic [9:0]  ctrl;
    logic        valid;
    logic [31:0] rsd, rtd, imm, pc4;
    logic [4:0]  rs, rt, rd;
    int          bcnt, fcnt;
  } slot_t;

  slot_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic slot_t model_reset();
    slot_t r;
    r.ctrl = 0; r.valid = 0; r.rsd = 0; r.rtd = 0; r.imm = 0; r.pc4 = 0;
    r.rs = 0; r.rt = 0; r.rd = 0; r.bcnt = 0; r.fcnt = 0;
    return r;
  endfunction

  // A load in EX whose destination is read by the instruction in decode.
  function automatic bit load_use();
    bit reads_rt;
    reads_rt = (id_ctrl[8] == 1'b0) || (id_ctrl[7] == 1'b1);
    if (!id_valid || !m.valid || !m.ctrl[3] || m.rt == 0) return 0;
    if (flush || hold) return 0;
    return (m.rt == id_rs) || (reads_rt && m.rt == id_rt);
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_ex(input string pfx);
    chk({pfx, "_ctrl"},  {22'd0, ex_ctrl}, {22'd0, m.ctrl});
    chk({pfx, "_valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
    chk({pfx, "_rsd"},   ex_rs_data, m.rsd);
    chk({pfx, "_rtd"},   ex_rt_data, m.rtd);
    chk({pfx, "_imm"},   ex_imm, m.imm);
    chk({pfx, "_pc4"},   ex_pc4, m.pc4);
    chk({pfx, "_rs"},    {27'd0, ex_rs}, {27'd0, m.rs});
    chk({pfx, "_rt"},    {27'd0, ex_rt}, {27'd0, m.rt});
    chk({pfx, "_rd"},    {27'd0, ex_rd}, {27'd0, m.rd});
`ifdef HAZARD_STATS_EN
    chk({pfx, "_bcnt"},  {16'd0, bubble_cnt}, m.bcnt);
    chk({pfx, "_fcnt"},  {16'd0, flush_cnt}, m.fcnt);
`endif
  endtask

  // Check the same-cycle enables, take one clock, then check EX contents.
  task automatic step();
    slot_t n;
    bit    lu;
    #1;
    lu = load_use();
    chk("stall", {31'd0, stall}, {31'd0, lu});
    chk("pc_write", {31'd0, pc_write}, {31'd0, !(lu || hold)});
    chk("ifid_write", {31'd0, ifid_write}, {31'd0, !(lu || hold)});
    n = m;
    if (flush || !hold) begin
      n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm; n.pc4 = id_pc4;
      n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
      if (flush || lu || !id_valid) begin
        n.ctrl = 0;
        n.valid = 0;
      end else begin
        n.ctrl = id_ctrl;
        n.valid = 1;
      end
    end
    if (flush) n.fcnt = sat16(m.fcnt + 1);
    if (lu)    n.bcnt = sat16(m.bcnt + 1);
    @(posedge clk);
    m = n;
    #1;
    check_ex("ex");
  endtask

  task automatic drive(input logic [9:0] c, input logic v, input logic [4:0] rs_i,
                       input logic [4:0] rt_i, input logic [4:0] rd_i,
                       input logic fl, input logic hd);
    id_ctrl = c; id_valid = v; id_rs = rs_i; id_rt = rt_i; id_rd = rd_i;
    flush = fl; hold = hd;
    id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom; id_pc4 = $urandom;
  endtask

  // Assert reset away from any clock edge and release it on the next falling edge.
  task automatic reset_now();
    rst = 1'b1;
    #1;
    m = model_reset();
    chk("rst_ctrl", {22'd0, ex_ctrl}, 32'd0);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_pcw", {31'd0, pc_write}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    check_ex("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(10'h000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    m = model_reset();
    chk("por_pcw", {31'd0, pc_write}, 32'd1);
    check_ex("por");
    @(negedge clk);
    rst = 1'b0;

    // R-type pass-through
    drive(10'h221, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    id_rs_data = 32'h0000_0005;
    step();
    chk("pt_ctrl", {22'd0, ex_ctrl}, 32'h221);
    chk("pt_rsd", ex_rs_data, 32'd5);

    // asynchronous reset while EX holds a valid instruction
    reset_now();

    // load-use: lw $8 then add reading $8
    drive(10'h318, 1'b1, 5'd3, 5'd8, 5'd0, 1'b0, 1'b0);
    step();
    drive(10'h221, 1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_pcw", {31'd0, pc_write}, 32'd0);
    step();
    chk("lu_bub_ctrl", {22'd0, ex_ctrl}, 32'd0);
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_stall", {31'd0, stall}, 32'd0);
    step();
    chk("lu_add_ctrl", {22'd0, ex_ctrl}, 32'h221);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);

    // no stall through $0
    drive(10'h318, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(10'h221, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    #1;
    chk("r0_stall", {31'd0, stall}, 32'd0);
    step();

    // no stall for addi whose rt is only a destination
    drive(10'h318, 1'b1, 5'd3, 5'd8, 5'd0, 1'b0, 1'b0);
    step();
    drive(10'h300, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, 1'b0);
    #1;
    chk("addi_stall", {31'd0, stall}, 32'd0);
    step();

    // flush beats load-use
    drive(10'h318, 1'b1, 5'd3, 5'd8, 5'd0, 1'b0, 1'b0);
    step();
    drive(10'h221, 1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0);
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_pcw", {31'd0, pc_write}, 32'd1);
    step();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_ctrl", {22'd0, ex_ctrl}, 32'd0);

    // hold for three cycles with a sw in EX
    drive(10'h180, 1'b1, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(10'h221, 1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b1);
      #1;
      chk("hold_pcw", {31'd0, pc_write}, 32'd0);
      step();
      chk("hold_ctrl", {22'd0, ex_ctrl}, 32'h180);
    end

    // flush together with hold: bubble written, fetch frozen
    drive(10'h221, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    #1;
    chk("flhd_pcw", {31'd0, pc_write}, 32'd0);
    step();
    chk("flhd_valid", {31'd0, ex_valid}, 32'd0);

    // random traffic with small register numbers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(10'($urandom), ($urandom_range(3) != 0), 5'($urandom_range(3)),
            5'($urandom_range(3)), 5'($urandom_range(31)),
            ($urandom_range(7) == 0), ($urandom_range(7) == 0));
      if ($urandom_range(49) == 0) reset_now();
      else step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
